// File: rtl/router_inj_pkg.sv
// Shared definitions for the router injection path.
// Contents:
//   - bit offsets and widths of the 68-bit injection channel
//   - bit offsets and width of the 2-bit flow-control return
//   - the scheduler state enum
package router_inj_pkg;

  // Channel layout: [0] valid, [1] head, [2] tail, [3] vc, [67:4] payload
  localparam int CH_VALID    = 0;
  localparam int CH_HEAD     = 1;
  localparam int CH_TAIL     = 2;
  localparam int CH_VC       = 3;
  localparam int CH_DATA_LSB = 4;
  localparam int CH_WIDTH    = 68;
  localparam int DATA_WIDTH  = 64;

  // Flow-control return layout: [0] credit valid, [1] vc
  localparam int FC_VALID = 0;
  localparam int FC_VC    = 1;
  localparam int FC_WIDTH = 2;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index with the highest priority this cycle
//   grant - one-hot grant of the first request at or after ptr (wrapping),
//           all-zero when nothing is requested
module rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant
);

  // Walk the requesters starting at ptr; the modulo keeps the wrap correct
  // even when NUM_REQ is not a power of two.
  always_comb begin : pickWinner
    int             sum;
    logic [PTR_W-1:0] idx;
    logic           found;
    grant = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = (int'(ptr) + k) % NUM_REQ;
      idx = PTR_W'(sum);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/inj_port_scheduler.sv
// Injection-port scheduler: shares the router's port-4 channel among
// NUM_REQ local sources, one whole packet at a time, round-robin, with
// per-VC credit counters so the router input buffers never overflow.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   req_valid/head/tail  - per-requester flit handshake and framing
//   req_vc               - packet VC, only looked at with the head flit
//   req_data             - payloads, requester i at [64*i +: 64]
//   req_ready            - per-requester accept (combinational from state)
//   channel_out          - registered flit towards the router
//   flow_ctrl_in         - credit returns from the router
//   error                - sticky protocol/credit error
module inj_port_scheduler
  import router_inj_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_VCS   = 2,
  parameter int BUF_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_head,
  input  logic [NUM_REQ-1:0]         req_tail,
  input  logic [NUM_REQ-1:0]         req_vc,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [CH_WIDTH-1:0]        channel_out,
  input  logic [FC_WIDTH-1:0]        flow_ctrl_in,
  output logic                       error
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW    = $clog2(BUF_DEPTH + 1);

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      owner_q, owner_d;
  logic                  ownerVc_q, ownerVc_d;
  logic [PTR_W-1:0]      rrPtr_q, rrPtr_d;
  logic                  sentFirst_q, sentFirst_d;
  logic                  error_q, error_d;
  logic [CH_WIDTH-1:0]   channel_q, channel_d;
  logic [CW-1:0]         credit_q [NUM_VCS];
  logic [CW-1:0]         credit_d [NUM_VCS];

  logic [DATA_WIDTH-1:0] reqData [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    grant;
  logic [PTR_W-1:0]      winnerIdx;
  logic                  ownerReady;
  logic                  accept;

  // Unpack payloads and flag heads whose VC still has buffer space.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      reqData[i]  = req_data[DATA_WIDTH*i +: DATA_WIDTH];
      eligible[i] = req_valid[i] && req_head[i] && (credit_q[req_vc[i]] != '0);
    end
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ)) uArb (
    .req   (eligible),
    .ptr   (rrPtr_q),
    .grant (grant)
  );

  // One-hot grant to index of the winning requester.
  always_comb begin
    winnerIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) winnerIdx = PTR_W'(i);
    end
  end

  // Ready depends only on registered state so there is no valid->ready path.
  always_comb begin
    ownerReady         = (state_q == LOCKED) && (credit_q[ownerVc_q] != '0);
    req_ready          = '0;
    req_ready[owner_q] = ownerReady;
    accept             = ownerReady && req_valid[owner_q];
  end

  // Next-state: packet lock, flit forwarding, credit accounting and errors.
  always_comb begin : nextState
    logic sendVc;
    logic retVc;
    state_d     = state_q;
    owner_d     = owner_q;
    ownerVc_d   = ownerVc_q;
    rrPtr_d     = rrPtr_q;
    sentFirst_d = sentFirst_q;
    error_d     = error_q;
    channel_d   = '0;
    credit_d    = credit_q;
    sendVc      = 1'b0;
    retVc       = 1'b0;

    case (state_q)
      IDLE: begin
        if (|eligible) begin
          state_d     = LOCKED;
          owner_d     = winnerIdx;
          ownerVc_d   = req_vc[winnerIdx];
          sentFirst_d = 1'b0;
        end
      end
      LOCKED: begin
        if (accept) begin
          channel_d[CH_VALID]                      = 1'b1;
          channel_d[CH_HEAD]                       = req_head[owner_q];
          channel_d[CH_TAIL]                       = req_tail[owner_q];
          channel_d[CH_VC]                         = ownerVc_q;
          channel_d[CH_DATA_LSB +: DATA_WIDTH]     = reqData[owner_q];
          sentFirst_d                              = 1'b1;
          // A second head inside a packet is a source bug; still forward it.
          if (sentFirst_q && req_head[owner_q]) error_d = 1'b1;
          if (req_tail[owner_q]) begin
            state_d = IDLE;
            rrPtr_d = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A send and a return on the same VC cancel out; a return into a full
    // counter is a router-side protocol error and the count saturates.
    for (int v = 0; v < NUM_VCS; v++) begin
      sendVc = accept && (ownerVc_q == 1'(v));
      retVc  = flow_ctrl_in[FC_VALID] && (flow_ctrl_in[FC_VC] == 1'(v));
      if (sendVc && !retVc) begin
        credit_d[v] = credit_q[v] - 1'b1;
      end else if (retVc && !sendVc) begin
        if (credit_q[v] == CW'(BUF_DEPTH)) error_d = 1'b1;
        else                                credit_d[v] = credit_q[v] + 1'b1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      ownerVc_q   <= 1'b0;
      rrPtr_q     <= '0;
      sentFirst_q <= 1'b0;
      error_q     <= 1'b0;
      channel_q   <= '0;
      for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= CW'(BUF_DEPTH);
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ownerVc_q   <= ownerVc_d;
      rrPtr_q     <= rrPtr_d;
      sentFirst_q <= sentFirst_d;
      error_q     <= error_d;
      channel_q   <= channel_d;
      for (int v = 0; v < NUM_VCS; v++) credit_q[v] <= credit_d[v];
    end
  end

  assign channel_out = channel_q;
  assign error       = error_q;

endmodule

// File: tb/tb_inj_port_scheduler.sv
// Directed testbench for inj_port_scheduler (4 requesters, 2 VCs, depth 8).
module tb_inj_port_scheduler;
  import router_inj_pkg::*;

  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_head;
  logic [3:0]   req_tail;
  logic [3:0]   req_vc;
  logic [255:0] req_data;
  logic [3:0]   req_ready;
  logic [67:0]  channel_out;
  logic [1:0]   flow_ctrl_in;
  logic         error;

  logic [63:0]  tbData [4];
  int           checks;
  int           errors;

  assign req_data = {tbData[3], tbData[2], tbData[1], tbData[0]};

  inj_port_scheduler #(.NUM_REQ(4), .NUM_VCS(2), .BUF_DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_head     (req_head),
    .req_tail     (req_tail),
    .req_vc       (req_vc),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .channel_out  (channel_out),
    .flow_ctrl_in (flow_ctrl_in),
    .error        (error)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [67:0] mkFlit(logic h, logic t, logic vc, logic [63:0] d);
    return {d, vc, t, h, 1'b1};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [67:0] obs, input logic [67:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic v, input logic h,
                               input logic t, input logic vc, input logic [63:0] d);
    req_valid[r] = v;
    req_head[r]  = h;
    req_tail[r]  = t;
    req_vc[r]    = vc;
    tbData[r]    = d;
  endtask

  task automatic clearInputs();
    req_valid    = '0;
    req_head     = '0;
    req_tail     = '0;
    req_vc       = '0;
    flow_ctrl_in = '0;
    for (int r = 0; r < 4; r++) tbData[r] = '0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    clearInputs();
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Directed sequence; each section starts right after a clock edge.
  initial begin
    int owner;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    clearInputs();
    tick();
    tick();

    // Reset state
    checkOutput("rst_channel", channel_out, '0);
    checkOutput("rst_ready",   68'(req_ready), '0);
    checkOutput("rst_error",   68'(error), '0);
    checkOutput("rst_state",   68'(dut.state_q), 68'(IDLE));
    checkOutput("rst_cred0",   68'(dut.credit_q[0]), 68'd8);
    checkOutput("rst_cred1",   68'(dut.credit_q[1]), 68'd8);
    reset = 1'b1;

    // Single requester, 3-flit packet on VC1
    applyStimulus(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 64'hAAAA_0000_0000_0001);
    checkOutput("t1_ready_idle", 68'(req_ready), '0);
    tick();
    checkOutput("t1_ready_lock", 68'(req_ready), 68'b0001);
    checkOutput("t1_ch_c1", channel_out, '0);
    tick();
    checkOutput("t1_flit_head", channel_out, mkFlit(1'b1, 1'b0, 1'b1, 64'hAAAA_0000_0000_0001));
    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hAAAA_0000_0000_0002);
    tick();
    checkOutput("t1_flit_body", channel_out, mkFlit(1'b0, 1'b0, 1'b1, 64'hAAAA_0000_0000_0002));
    applyStimulus(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 64'hAAAA_0000_0000_0003);
    tick();
    checkOutput("t1_flit_tail", channel_out, mkFlit(1'b0, 1'b1, 1'b1, 64'hAAAA_0000_0000_0003));
    checkOutput("t1_state_idle", 68'(dut.state_q), 68'(IDLE));
    checkOutput("t1_cred1", 68'(dut.credit_q[1]), 68'd5);
    checkOutput("t1_cred0", 68'(dut.credit_q[0]), 68'd8);
    checkOutput("t1_rrptr", 68'(dut.rrPtr_q), 68'd1);
    clearInputs();
    tick();
    checkOutput("t1_ch_after", channel_out, '0);

    // Round-robin among four single-flit requesters, credits returned as used
    doReset();
    for (int r = 0; r < 4; r++)
      applyStimulus(2'(r), 1'b1, 1'b1, 1'b1, 1'b0, 64'hC0DE_0000_0000_0000 + 64'(r));
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i % 2 == 0) begin
        owner = ((i / 2) - 1) % 4;
        checkOutput("rr_flit", channel_out,
                    mkFlit(1'b1, 1'b1, 1'b0, 64'hC0DE_0000_0000_0000 + 64'(owner)));
        checkOutput("rr_ready_bubble", 68'(req_ready), '0);
      end else begin
        owner = ((i - 1) / 2) % 4;
        checkOutput("rr_bubble", channel_out, '0);
        checkOutput("rr_ready", 68'(4'b0001 << owner), 68'(req_ready));
      end
      flow_ctrl_in = {1'b0, channel_out[0]};
      if (i == 10) req_valid = '0;
    end
    tick();
    flow_ctrl_in = '0;
    checkOutput("rr_cred0", 68'(dut.credit_q[0]), 68'd8);
    checkOutput("rr_error", 68'(error), '0);
    checkOutput("rr_rrptr", 68'(dut.rrPtr_q), 68'd1);

    // VC0 credits exhausted mid-packet, one return releases the next flit
    applyStimulus(2'd2, 1'b1, 1'b1, 1'b0, 1'b0, 64'hB000_0000_0000_0000);
    tick();
    checkOutput("t3_ready_lock", 68'(req_ready), 68'b0100);
    tick();
    for (int j = 0; j < 7; j++) begin
      applyStimulus(2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 64'hB000_0000_0000_0010 + 64'(j));
      tick();
    end
    checkOutput("t3_ready_empty", 68'(req_ready), '0);
    checkOutput("t3_cred0_zero", 68'(dut.credit_q[0]), '0);
    tick();
    checkOutput("t3_ready_held", 68'(req_ready), '0);
    checkOutput("t3_ch_stall", channel_out, '0);
    applyStimulus(2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 64'hB000_0000_0000_00EE);
    flow_ctrl_in = 2'b01;
    tick();
    flow_ctrl_in = '0;
    checkOutput("t3_cred0_one", 68'(dut.credit_q[0]), 68'd1);
    checkOutput("t3_ready_back", 68'(req_ready), 68'b0100);
    tick();
    checkOutput("t3_flit_tail", channel_out, mkFlit(1'b0, 1'b1, 1'b0, 64'hB000_0000_0000_00EE));
    checkOutput("t3_rrptr", 68'(dut.rrPtr_q), 68'd3);
    clearInputs();

    // Simultaneous send and return on VC0 at count 3
    flow_ctrl_in = 2'b01;
    tick();
    tick();
    tick();
    flow_ctrl_in = '0;
    checkOutput("t4_cred0_three", 68'(dut.credit_q[0]), 68'd3);
    applyStimulus(2'd3, 1'b1, 1'b1, 1'b1, 1'b0, 64'hD000_0000_0000_0003);
    tick();
    checkOutput("t4_ready", 68'(req_ready), 68'b1000);
    flow_ctrl_in = 2'b01;
    tick();
    checkOutput("t4_flit", channel_out, mkFlit(1'b1, 1'b1, 1'b0, 64'hD000_0000_0000_0003));
    checkOutput("t4_cred0_same", 68'(dut.credit_q[0]), 68'd3);
    checkOutput("t4_error_none", 68'(error), '0);
    clearInputs();

    // Credit return on VC1 while already full
    flow_ctrl_in = 2'b11;
    tick();
    flow_ctrl_in = '0;
    checkOutput("t4_error_ovf", 68'(error), 68'd1);
    checkOutput("t4_cred1_sat", 68'(dut.credit_q[1]), 68'd8);
    tick();
    checkOutput("t4_error_sticky", 68'(error), 68'd1);

    // Head asserted on the second flit of a packet
    doReset();
    checkOutput("t5_error_clr", 68'(error), '0);
    applyStimulus(2'd1, 1'b1, 1'b1, 1'b0, 1'b1, 64'hE000_0000_0000_0001);
    tick();
    checkOutput("t5_ready", 68'(req_ready), 68'b0010);
    tick();
    checkOutput("t5_flit_head", channel_out, mkFlit(1'b1, 1'b0, 1'b1, 64'hE000_0000_0000_0001));
    applyStimulus(2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 64'hE000_0000_0000_0002);
    checkOutput("t5_error_before", 68'(error), '0);
    tick();
    checkOutput("t5_error_rise", 68'(error), 68'd1);
    checkOutput("t5_flit_badhead", channel_out, mkFlit(1'b1, 1'b0, 1'b1, 64'hE000_0000_0000_0002));
    applyStimulus(2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 64'hE000_0000_0000_0003);
    tick();
    checkOutput("t5_flit_tail", channel_out, mkFlit(1'b0, 1'b1, 1'b1, 64'hE000_0000_0000_0003));
    checkOutput("t5_state_idle", 68'(dut.state_q), 68'(IDLE));
    clearInputs();

    // Reset pulsed mid-packet
    applyStimulus(2'd0, 1'b1, 1'b1, 1'b0, 1'b0, 64'hF000_0000_0000_0001);
    tick();
    tick();
    checkOutput("t6_flit_head", channel_out, mkFlit(1'b1, 1'b0, 1'b0, 64'hF000_0000_0000_0001));
    applyStimulus(2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 64'hF000_0000_0000_0002);
    reset = 1'b0;
    #1;
    checkOutput("t6_ch_async", channel_out, '0);
    checkOutput("t6_ready_async", 68'(req_ready), '0);
    clearInputs();
    tick();
    reset = 1'b1;
    tick();
    checkOutput("t6_state", 68'(dut.state_q), 68'(IDLE));
    checkOutput("t6_cred0", 68'(dut.credit_q[0]), 68'd8);
    checkOutput("t6_cred1", 68'(dut.credit_q[1]), 68'd8);
    checkOutput("t6_rrptr", 68'(dut.rrPtr_q), '0);
    checkOutput("t6_error", 68'(error), '0);
    checkOutput("t6_ch", channel_out, '0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
